image_frame_capture: RTL

- Upstream neighbour of the VGA image display stage.
- Accepts a byte-serial grayscale pixel stream (raster order, with a start-of-frame marker) and assembles it into a back buffer of WIDTH*HEIGHT bytes.
- When the back buffer is complete, copies it to a packed front-buffer output. That output drives the display stage's image input directly and remains stable between swaps.
- A hold input blocks the swap so the displayed image cannot change while the consumer is busy.

---
 rtl/image_frame_capture.sv | 91 +++++++++
 1 files changed

// File: rtl/image_frame_capture.sv
// Purpose: assembles a raster-order, byte-serial grayscale pixel stream into a back buffer and
//          copies the complete frame to a packed, stable front buffer that drives the display stage.
// Latency: the front buffer updates one cycle after the last pixel is accepted; frame_done pulses that cycle.
// Backpressure: pix_ready drops for one cycle per frame during the swap, and stays low while hold blocks the swap.
// Ports: clk/reset (async, active-low); pix_data/pix_valid/pix_sof/pix_ready pixel input;
//        hold freezes the front buffer; image is the front buffer; frame_done/frame_err status; wr_index debug.
module image_frame_capture #(
  parameter  int WIDTH  = 28,
  parameter  int HEIGHT = 28,
  parameter  int PIX_W  = 8,
  localparam int N      = WIDTH * HEIGHT,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PIX_W-1:0]          pix_data,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  output logic                      pix_ready,
  input  logic                      hold,
  output logic [N-1:0][PIX_W-1:0]   image,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic [IW-1:0]             wr_index
);

  typedef enum logic {FILL, SWAP} state_t;

  state_t                    state;
  logic [N-1:0][PIX_W-1:0]   back;
  logic                      xfer;

  assign pix_ready = (state == FILL);
  assign xfer      = pix_valid && pix_ready;

  // Back buffer has no reset: its contents only matter once a full frame has been written.
  always_ff @(posedge clk) begin
    if (xfer) begin
      if (pix_sof)
        back[0] <= pix_data;
      else if (wr_index != '0)
        back[wr_index] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      wr_index   <= '0;
      image      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (pix_valid) begin
            if (pix_sof) begin
              // A start marker anywhere but index 0 truncates the frame in progress; restart from it.
              if (wr_index != '0)
                frame_err <= 1'b1;
              if (N == 1) begin
                wr_index <= '0;
                state    <= SWAP;
              end else begin
                wr_index <= IW'(1);
              end
            end else if (wr_index == '0) begin
              // Data before any start marker cannot be placed; drop it and flag.
              frame_err <= 1'b1;
            end else if (wr_index == IW'(N - 1)) begin
              wr_index <= '0;
              state    <= SWAP;
            end else begin
              wr_index <= wr_index + IW'(1);
            end
          end
        end
        SWAP: begin
          if (!hold) begin
            image      <= back;
            frame_done <= 1'b1;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
